// File: rtl/pet_clk_pkg.sv
// pet_clk_pkg
//   Shared types and defaults for the PET clock-enable / reset sequencer.
//   - reset_state_t : states of the system reset sequencer
//   - RATE_W_DEF    : default width of CPU divider values
//   - RATES_DEF     : default CPU rate table, entry i at bits [i*RATE_W +: RATE_W]
//   - sel_width()   : width of a table index, never narrower than 1 bit
package pet_clk_pkg;

  typedef enum logic [1:0] {
    S_POR     = 2'd0,
    S_STRETCH = 2'd1,
    S_RUN     = 2'd2
  } reset_state_t;

  localparam int RATE_W_DEF    = 7;
  localparam int NUM_RATES_DEF = 4;

  // Entry 0 sits in the least significant slot, so speed_sel=0 selects 6
  // (period 7) and speed_sel=3 selects 55 (period 56).
  localparam logic [NUM_RATES_DEF*RATE_W_DEF-1:0] RATES_DEF =
    {7'd55, 7'd27, 7'd13, 7'd6};

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pet_reset_seq.sv
// pet_reset_seq
//   Power-on delay and reset stretcher producing the core-wide sys_reset.
//   After reset_n releases, sys_reset is held for POR_CYCLES clocks, then
//   for STRETCH further clocks; any rst_req restarts the stretch window.
// Ports
//   clk               in   system clock
//   reset_n           in   synchronous active-low reset
//   rst_req           in   user/OSD reset request (level)
//   sys_reset         out  registered active-high reset for the core
//   sys_reset_pending out  sys_reset is about to rise on this edge
//   state             out  current sequencer state (debug visibility)
module pet_reset_seq
  import pet_clk_pkg::*;
#(
  parameter int unsigned POR_CYCLES = 20_000_000,
  parameter int unsigned STRETCH    = 15
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         rst_req,
  output logic         sys_reset,
  output logic         sys_reset_pending,
  output reset_state_t state
);

  localparam int ST_W = (STRETCH > 1) ? $clog2(STRETCH) : 1;
  localparam logic [31:0]    POR_LOAD = 32'(POR_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STRETCH - 1);

  reset_state_t    state_q, state_d;
  logic [31:0]     por_cnt_q, por_cnt_d;
  logic [ST_W-1:0] st_cnt_q, st_cnt_d;
  logic            sys_reset_q, sys_reset_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_POR;
      por_cnt_q   <= POR_LOAD;
      st_cnt_q    <= '0;
      sys_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      por_cnt_q   <= por_cnt_d;
      st_cnt_q    <= st_cnt_d;
      sys_reset_q <= sys_reset_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    por_cnt_d = por_cnt_q;
    st_cnt_d  = st_cnt_q;
    case (state_q)
      S_POR: begin
        // rst_req is not looked at here: the stretch that follows already
        // covers any request still held when the POR delay ends.
        if (por_cnt_q == '0) begin
          state_d  = S_STRETCH;
          st_cnt_d = '0;
        end else begin
          por_cnt_d = por_cnt_q - 32'd1;
        end
      end
      S_STRETCH: begin
        if (rst_req) begin
          st_cnt_d = '0;
        end else if (st_cnt_q == ST_LAST) begin
          state_d = S_RUN;
        end else begin
          st_cnt_d = st_cnt_q + ST_W'(1);
        end
      end
      S_RUN: begin
        if (rst_req) begin
          state_d  = S_STRETCH;
          st_cnt_d = '0;
        end
      end
      default: begin
        state_d   = S_POR;
        por_cnt_d = POR_LOAD;
        st_cnt_d  = '0;
      end
    endcase
    sys_reset_d = (state_d != S_RUN);
  end

  assign sys_reset         = sys_reset_q;
  assign sys_reset_pending = sys_reset_d && !sys_reset_q;
  assign state             = state_q;

endmodule

// File: rtl/pet_ce_reset_gen.sv
// pet_ce_reset_gen
//   Clock-enable and reset sequencer for the PET core. All outputs are
//   registered and derived from the single system clock.
// Ports
//   clk, reset_n   system clock and synchronous active-low reset
//   rst_req        user/OSD reset request (level)
//   speed_sel      CPU rate table index (out-of-range -> last entry)
//   tape_active    tape playback running
//   tape_fast      tape turbo selected (uses TAPE_RATE while tape_active)
//   ram_ready      tape SDRAM data valid; low during playback stalls CPU
//   pause          freeze the CPU
//   ce_pix_x2      pixel enable at twice the pixel rate
//   ce_pix_p/n     pixel enables, phase 0 and half-period phase
//   ce_cpu         CPU enable at the start of each CPU period
//   ce_cpu_n       CPU enable at the middle of each CPU period
//   cpu_stalled    a CPU tick was dropped by stall/pause
//   rate_cur       divider currently in effect
//   sys_reset      active-high reset to the rest of the core
// Handshake: none; all enables are single-cycle pulses with no back-pressure.
module pet_ce_reset_gen
  import pet_clk_pkg::*;
#(
  parameter int PIX_LOG2  = 3,
  parameter int NUM_RATES = NUM_RATES_DEF,
  parameter int RATE_W    = RATE_W_DEF,
  parameter logic [NUM_RATES*RATE_W-1:0] RATES = RATES_DEF,
  parameter logic [RATE_W-1:0] TAPE_RATE = RATE_W'(2),
  parameter int unsigned POR_CYCLES = 20_000_000,
  parameter int unsigned STRETCH    = 15,
  localparam int SEL_W = sel_width(NUM_RATES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rst_req,
  input  logic [SEL_W-1:0]  speed_sel,
  input  logic              tape_active,
  input  logic              tape_fast,
  input  logic              ram_ready,
  input  logic              pause,
  output logic              ce_pix_x2,
  output logic              ce_pix_p,
  output logic              ce_pix_n,
  output logic              ce_cpu,
  output logic              ce_cpu_n,
  output logic              cpu_stalled,
  output logic [RATE_W-1:0] rate_cur,
  output logic              sys_reset
);

  localparam logic [PIX_LOG2-1:0] PIX_HALF = PIX_LOG2'(1 << (PIX_LOG2 - 1));
  localparam logic [RATE_W-1:0]   RATE0    = RATES[RATE_W-1:0];

  // ---------------------------------------------------------------------
  // Reset sequencer
  // ---------------------------------------------------------------------
  logic         sys_reset_pending;
  reset_state_t reset_state;

  pet_reset_seq #(
    .POR_CYCLES (POR_CYCLES),
    .STRETCH    (STRETCH)
  ) u_reset_seq (
    .clk               (clk),
    .reset_n           (reset_n),
    .rst_req           (rst_req),
    .sys_reset         (sys_reset),
    .sys_reset_pending (sys_reset_pending),
    .state             (reset_state)
  );

  // ---------------------------------------------------------------------
  // Pixel enables: free-running divider, never gated
  // ---------------------------------------------------------------------
  logic [PIX_LOG2-1:0] pix_div_q, pix_div_d;
  logic ce_pix_x2_q, ce_pix_x2_d;
  logic ce_pix_p_q, ce_pix_p_d;
  logic ce_pix_n_q, ce_pix_n_d;

  always_comb begin
    pix_div_d   = pix_div_q + PIX_LOG2'(1);
    ce_pix_p_d  = (pix_div_q == '0);
    ce_pix_n_d  = (pix_div_q == PIX_HALF);
    ce_pix_x2_d = (pix_div_q[PIX_LOG2-2:0] == '0);
  end

  // ---------------------------------------------------------------------
  // CPU divider and gated enables
  // ---------------------------------------------------------------------
  logic [RATE_W-1:0] cpu_div_q, cpu_div_d;
  logic [RATE_W-1:0] rate_cur_q, rate_cur_d;
  logic [RATE_W-1:0] next_rate;
  logic [RATE_W:0]   half_pt;
  int unsigned       sel_idx;
  logic              wrap, stall, gate;
  logic ce_cpu_q, ce_cpu_d;
  logic ce_cpu_n_q, ce_cpu_n_d;
  logic cpu_stalled_q, cpu_stalled_d;

  always_comb begin
    sel_idx = 32'(speed_sel);
    if (sel_idx > 32'(NUM_RATES - 1)) begin
      sel_idx = 32'(NUM_RATES - 1);
    end
    if (tape_active && tape_fast) begin
      next_rate = TAPE_RATE;
    end else begin
      next_rate = RATES[sel_idx*RATE_W +: RATE_W];
    end
  end

  always_comb begin
    wrap  = (cpu_div_q == rate_cur_q);
    stall = tape_active && !ram_ready;
    gate  = stall || pause;
    // One bit wider so rate_cur = all-ones does not overflow.
    half_pt = ({1'b0, rate_cur_q} + (RATE_W+1)'(1)) >> 1;

    cpu_div_d  = cpu_div_q + RATE_W'(1);
    rate_cur_d = rate_cur_q;
    // The rate only changes on a wrap, so every period runs to completion
    // at the rate it started with.
    if (wrap) begin
      cpu_div_d  = '0;
      rate_cur_d = next_rate;
    end

    // Ticks lost to gating are dropped; the divider keeps its grid. The CPU
    // keeps being clocked while sys_reset is high so it can process the
    // reset; only the edge where reset is about to rise is skipped.
    ce_cpu_d      = (cpu_div_q == '0) && !gate && !sys_reset_pending;
    ce_cpu_n_d    = ({1'b0, cpu_div_q} == half_pt) && !gate;
    cpu_stalled_d = (cpu_div_q == '0) && gate;
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pix_div_q     <= '0;
      ce_pix_x2_q   <= 1'b0;
      ce_pix_p_q    <= 1'b0;
      ce_pix_n_q    <= 1'b0;
      cpu_div_q     <= '0;
      rate_cur_q    <= RATE0;
      ce_cpu_q      <= 1'b0;
      ce_cpu_n_q    <= 1'b0;
      cpu_stalled_q <= 1'b0;
    end else begin
      pix_div_q     <= pix_div_d;
      ce_pix_x2_q   <= ce_pix_x2_d;
      ce_pix_p_q    <= ce_pix_p_d;
      ce_pix_n_q    <= ce_pix_n_d;
      cpu_div_q     <= cpu_div_d;
      rate_cur_q    <= rate_cur_d;
      ce_cpu_q      <= ce_cpu_d;
      ce_cpu_n_q    <= ce_cpu_n_d;
      cpu_stalled_q <= cpu_stalled_d;
    end
  end

  assign ce_pix_x2   = ce_pix_x2_q;
  assign ce_pix_p    = ce_pix_p_q;
  assign ce_pix_n    = ce_pix_n_q;
  assign ce_cpu      = ce_cpu_q;
  assign ce_cpu_n    = ce_cpu_n_q;
  assign cpu_stalled = cpu_stalled_q;
  assign rate_cur    = rate_cur_q;

endmodule

// File: tb/tb_pet_ce_reset_gen.sv
// tb_pet_ce_reset_gen
//   Directed bench for pet_ce_reset_gen with POR_CYCLES=100, STRETCH=15.
//   Edge numbers k count rising edges after the last edge with reset_n low;
//   outputs are sampled 1 time unit after each edge.
module tb_pet_ce_reset_gen;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rst_req;
  logic [1:0] speed_sel;
  logic       tape_active;
  logic       tape_fast;
  logic       ram_ready;
  logic       pause;
  logic       ce_pix_x2, ce_pix_p, ce_pix_n;
  logic       ce_cpu, ce_cpu_n, cpu_stalled;
  logic [6:0] rate_cur;
  logic       sys_reset;

  int checks = 0;
  int errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  pet_ce_reset_gen #(
    .POR_CYCLES (100),
    .STRETCH    (15)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rst_req     (rst_req),
    .speed_sel   (speed_sel),
    .tape_active (tape_active),
    .tape_fast   (tape_fast),
    .ram_ready   (ram_ready),
    .pause       (pause),
    .ce_pix_x2   (ce_pix_x2),
    .ce_pix_p    (ce_pix_p),
    .ce_pix_n    (ce_pix_n),
    .ce_cpu      (ce_cpu),
    .ce_cpu_n    (ce_cpu_n),
    .cpu_stalled (cpu_stalled),
    .rate_cur    (rate_cur),
    .sys_reset   (sys_reset)
  );

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pix_p"},  0, 32'(ce_pix_p),    32'd0);
    chk({tag, "_pix_n"},  0, 32'(ce_pix_n),    32'd0);
    chk({tag, "_pix_x2"}, 0, 32'(ce_pix_x2),   32'd0);
    chk({tag, "_cpu"},    0, 32'(ce_cpu),      32'd0);
    chk({tag, "_cpu_n"},  0, 32'(ce_cpu_n),    32'd0);
    chk({tag, "_stall"},  0, 32'(cpu_stalled), 32'd0);
    chk({tag, "_rate"},   0, 32'(rate_cur),    32'd6);
    chk({tag, "_sysrst"}, 0, 32'(sys_reset),   32'd1);
  endtask

  initial begin
    reset_n     = 1'b0;
    rst_req     = 1'b0;
    speed_sel   = 2'd0;
    tape_active = 1'b0;
    tape_fast   = 1'b0;
    ram_ready   = 1'b1;
    pause       = 1'b0;
    step(3);
    chk_reset_state("rst");
    reset_n = 1'b1;

    // Pixel grid, rate-6 CPU grid, POR + stretch release at edge 115.
    for (int k = 1; k <= 130; k++) begin
      step(1);
      chk("pix_p",  k, 32'(ce_pix_p),  32'(k % 8 == 1));
      chk("pix_n",  k, 32'(ce_pix_n),  32'(k % 8 == 5));
      chk("pix_x2", k, 32'(ce_pix_x2), 32'(k % 4 == 1));
      chk("pix_pn_excl", k, 32'(ce_pix_p && ce_pix_n), 32'd0);
      chk("cpu_r6",   k, 32'(ce_cpu),   32'(k % 7 == 1));
      chk("cpu_n_r6", k, 32'(ce_cpu_n), 32'(k % 7 == 4));
      chk("por_sysrst", k, 32'(sys_reset), 32'(k < 115));
    end

    // Switch to rate 55 mid-period: old period ends at edge 133.
    speed_sel = 2'd3;
    for (int k = 131; k <= 250; k++) begin
      step(1);
      chk("rate_sw", k, 32'(rate_cur), (k >= 133) ? 32'd55 : 32'd6);
      chk("cpu_r55", k, 32'(ce_cpu),
          32'(k >= 134 && (k - 134) % 56 == 0));
      chk("cpu_n_r55", k, 32'(ce_cpu_n),
          32'(k >= 134 && (k - 134) % 56 == 28));
    end

    // Pause for 200 clocks: ticks dropped, stall pulses on the grid.
    pause = 1'b1;
    for (int k = 251; k <= 450; k++) begin
      step(1);
      chk("pause_cpu",   k, 32'(ce_cpu),      32'd0);
      chk("pause_cpu_n", k, 32'(ce_cpu_n),    32'd0);
      chk("pause_stall", k, 32'(cpu_stalled), 32'((k - 134) % 56 == 0));
    end
    pause = 1'b0;
    for (int k = 451; k <= 480; k++) begin
      step(1);
      chk("unpause_cpu",   k, 32'(ce_cpu),      32'(k == 470));
      chk("unpause_stall", k, 32'(cpu_stalled), 32'd0);
    end

    // Tape turbo: rate 2 after the wrap at edge 525.
    tape_active = 1'b1;
    tape_fast   = 1'b1;
    for (int k = 481; k <= 540; k++) begin
      step(1);
      chk("tape_rate", k, 32'(rate_cur), (k >= 525) ? 32'd2 : 32'd55);
      chk("tape_cpu",  k, 32'(ce_cpu),
          32'(k >= 526 && (k - 526) % 3 == 0));
      chk("tape_cpu_n", k, 32'(ce_cpu_n),
          32'(k == 498 || (k >= 527 && (k - 527) % 3 == 0)));
    end

    // SDRAM not ready during playback stalls the CPU.
    ram_ready = 1'b0;
    for (int k = 541; k <= 560; k++) begin
      step(1);
      chk("ram_cpu",   k, 32'(ce_cpu),      32'd0);
      chk("ram_cpu_n", k, 32'(ce_cpu_n),    32'd0);
      chk("ram_stall", k, 32'(cpu_stalled), 32'((k - 526) % 3 == 0));
    end
    ram_ready   = 1'b1;
    tape_active = 1'b0;
    tape_fast   = 1'b0;
    step(1);
    chk("tape_off_rate", 561, 32'(rate_cur), 32'd55);

    // rst_req for 3 clocks in S_RUN.
    rst_req = 1'b1;
    step(1);
    chk("req_rise", 562, 32'(sys_reset), 32'd1);
    step(2);
    rst_req = 1'b0;
    for (int k = 565; k <= 585; k++) begin
      step(1);
      chk("req_stretch", k, 32'(sys_reset), 32'(k < 579));
    end

    // reset_n low mid-stretch restarts the full power-on sequence.
    rst_req = 1'b1;
    step(1);
    rst_req = 1'b0;
    step(5);
    chk("mid_stretch", 591, 32'(sys_reset), 32'd1);
    reset_n = 1'b0;
    step(1);
    chk_reset_state("rst2");
    reset_n = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      step(1);
      chk("por2_sysrst", k, 32'(sys_reset), 32'(k < 115));
      chk("por2_pix_p",  k, 32'(ce_pix_p),  32'(k % 8 == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
